// File: rtl/im_port_arbiter_if.sv
// Shared instruction-memory port bundle: fetch and loader requests
// on one side, the single-port memory on the other.
interface im_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;

  logic          ld_req;
  logic          ld_we;
  logic          ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ld_req, ld_we, ld_lock,
    input  ld_addr, ld_wdata,
    input  mem_rdata,
    output if_gnt, if_rdata, if_rvalid,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ld_req, ld_we, ld_lock,
    output ld_addr, ld_wdata,
    output mem_rdata,
    input  if_gnt, if_rdata, if_rvalid,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Fetch/loader arbiter for the single-port instruction memory,
// with loader starvation guard and locked burst ownership.
module im_port_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  im_port_arbiter_if.slave  bus
);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LD
  } own_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  own_t       rd_owner;
  logic [3:0] starve_cnt;

  logic ld_win;
  logic if_gnt;
  logic ld_gnt;

  always_comb begin
    ld_win = 1'b0;
    unique case (state)
      LOCKED:  ld_win = bus.ld_req;
      default: ld_win = bus.ld_req &
                        (!bus.if_req |
                         (starve_cnt == SMAX));
    endcase
  end

  // grants are squashed while reset is held
  assign ld_gnt = rst_n & ld_win;
  assign if_gnt = rst_n & bus.if_req &
                  (state == ARB) & !ld_win;

  assign bus.if_gnt = if_gnt;
  assign bus.ld_gnt = ld_gnt;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      if_gnt: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
      ld_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.ld_we;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      unique case (state)
        ARB: if (ld_gnt & bus.ld_lock)
          state <= LOCKED;
        LOCKED: if (!bus.ld_lock)
          state <= ARB;
        default: state <= ARB;
      endcase

      if (!bus.ld_req | ld_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 4'd1;

      if (if_gnt)
        rd_owner <= OWN_IF;
      else if (ld_gnt & !bus.ld_we)
        rd_owner <= OWN_LD;
      else
        rd_owner <= OWN_NONE;
    end
  end

  assign bus.if_rvalid = rst_n &
                         (rd_owner == OWN_IF);
  assign bus.ld_rvalid = rst_n &
                         (rd_owner == OWN_LD);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ld_rdata  = bus.mem_rdata;

endmodule
